// File: rtl/ym3438_pg_pkg.sv
// Shared types, constants and the OPN2 detune table for the phase generator.
// Detune rows are indexed by keycode; columns by detune magnitude 0..3.
package ym3438_pg_pkg;

    localparam int unsigned SLOTS   = 24;
    localparam int unsigned PHASE_W = 20;
    localparam int unsigned BF_W    = 17;

    // Per-slot operands latched on the c1 strobe.
    typedef struct packed {
        logic [11:0] fnum_lfo;
        logic [2:0]  fnum_hi;
        logic [2:0]  block;
        logic [2:0]  dt;
        logic [3:0]  mul;
        logic        pg_reset;
    } pg_slot_in_t;

    localparam logic [4:0] PG_DT_TABLE [32][4] = '{
        '{5'd0, 5'd0, 5'd1,  5'd2},  '{5'd0, 5'd0, 5'd1,  5'd2},
        '{5'd0, 5'd0, 5'd1,  5'd2},  '{5'd0, 5'd0, 5'd1,  5'd2},
        '{5'd0, 5'd1, 5'd2,  5'd2},  '{5'd0, 5'd1, 5'd2,  5'd3},
        '{5'd0, 5'd1, 5'd2,  5'd3},  '{5'd0, 5'd1, 5'd2,  5'd3},
        '{5'd0, 5'd1, 5'd2,  5'd4},  '{5'd0, 5'd1, 5'd3,  5'd4},
        '{5'd0, 5'd1, 5'd3,  5'd4},  '{5'd0, 5'd1, 5'd3,  5'd5},
        '{5'd0, 5'd2, 5'd4,  5'd5},  '{5'd0, 5'd2, 5'd4,  5'd6},
        '{5'd0, 5'd2, 5'd4,  5'd6},  '{5'd0, 5'd2, 5'd5,  5'd7},
        '{5'd0, 5'd2, 5'd5,  5'd8},  '{5'd0, 5'd3, 5'd6,  5'd8},
        '{5'd0, 5'd3, 5'd6,  5'd9},  '{5'd0, 5'd3, 5'd7,  5'd10},
        '{5'd0, 5'd4, 5'd8,  5'd11}, '{5'd0, 5'd4, 5'd8,  5'd12},
        '{5'd0, 5'd4, 5'd9,  5'd13}, '{5'd0, 5'd5, 5'd10, 5'd14},
        '{5'd0, 5'd5, 5'd11, 5'd16}, '{5'd0, 5'd6, 5'd12, 5'd17},
        '{5'd0, 5'd6, 5'd13, 5'd19}, '{5'd0, 5'd7, 5'd14, 5'd20},
        '{5'd0, 5'd8, 5'd16, 5'd22}, '{5'd0, 5'd8, 5'd16, 5'd22},
        '{5'd0, 5'd8, 5'd16, 5'd22}, '{5'd0, 5'd8, 5'd16, 5'd22}
    };

    // Keycode: block plus a two-bit note derived from the top fnum bits.
    function automatic logic [4:0] pg_keycode(input logic [2:0] block,
                                              input logic [2:0] fnum_hi,
                                              input logic       f7);
        logic n4;
        n4 = (fnum_hi[2] & (fnum_hi[1] | fnum_hi[0] | f7))
           | (~fnum_hi[2] & fnum_hi[1] & fnum_hi[0] & f7);
        return {block, fnum_hi[2], n4};
    endfunction

endpackage

// File: rtl/ym3438_pg_detune.sv
// Block shift, keycode, detune lookup and signed add for one slot (combinational).
// The result wraps modulo 2^17 on underflow, matching the silicon.
module ym3438_pg_detune
    import ym3438_pg_pkg::*;
(
    input  logic [11:0]     fnum_lfo,
    input  logic [2:0]      fnum_hi,
    input  logic [2:0]      block,
    input  logic [2:0]      dt,
    output logic [BF_W-1:0] bfd
);

    logic [BF_W+1:0] shifted;
    logic [BF_W-1:0] bf;
    logic [4:0]      kc;
    logic [4:0]      dv;
    logic [BF_W-1:0] dv_ext;

    always_comb begin
        // Shift in a wide enough word that block 7 never loses high bits.
        shifted = (BF_W+2)'(fnum_lfo) << block;
        bf      = shifted[BF_W+1:2];
        kc      = pg_keycode(block, fnum_hi, fnum_lfo[8]);
        dv      = PG_DT_TABLE[kc][dt[1:0]];
        dv_ext  = BF_W'(dv);
        bfd     = dt[2] ? (bf - dv_ext) : (bf + dv_ext);
    end

endmodule

// File: rtl/ym3438_sr_bit_array.sv
// Generic shift-register array: LEN entries of DATA_WIDTH bits, advancing when en is high.
// Output is the oldest entry, so a value re-emerges LEN shifts after it went in.
module ym3438_sr_bit_array #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned LEN        = 24
) (
    input  logic                  MCLK,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [LEN];

    always_ff @(posedge MCLK) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[0] <= data_in;
            for (int i = 1; i < LEN; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_out = mem_q[LEN-1];

endmodule

// File: rtl/ym3438_phase_gen.sv
// YM3438 phase generator: fnum/block/detune/multiple to increment, 24-slot phase ring.
// Define PG_DBG_EN to expose the stage-B increment and a slot counter as debug outputs.
module ym3438_phase_gen #(
    parameter int unsigned SLOTS   = ym3438_pg_pkg::SLOTS,
    parameter int unsigned PHASE_W = ym3438_pg_pkg::PHASE_W
) (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        c1,
    input  logic        c2,
    input  logic [11:0] fnum_lfo,
    input  logic [2:0]  fnum_hi,
    input  logic [2:0]  block,
    input  logic [2:0]  dt,
    input  logic [3:0]  mul,
    input  logic        pg_reset,
    output logic [9:0]  phase_out
`ifdef PG_DBG_EN
    ,
    output logic [19:0] pg_inc_dbg,
    output logic [4:0]  pg_slot_dbg
`endif
);

    import ym3438_pg_pkg::*;

    pg_slot_in_t        cap_d;
    pg_slot_in_t        cap_q;
    logic [BF_W-1:0]    bfd;
    logic [BF_W+3:0]    prod;
    logic [PHASE_W-1:0] inc_d;
    logic [PHASE_W-1:0] inc_q;
    logic               pg_reset_dly_q;
    logic [PHASE_W-1:0] ring_tail;
    logic [PHASE_W-1:0] ring_head;
    logic [9:0]         phase_q;

    always_comb begin
        cap_d          = '0;
        cap_d.fnum_lfo = fnum_lfo;
        cap_d.fnum_hi  = fnum_hi;
        cap_d.block    = block;
        cap_d.dt       = dt;
        cap_d.mul      = mul;
        cap_d.pg_reset = pg_reset;
    end

    // Stage A: operand capture on c1.
    always_ff @(posedge MCLK) begin
        if (IC) begin
            cap_q <= '0;
        end else if (c1) begin
            cap_q <= cap_d;
        end
    end

    ym3438_pg_detune u_detune (
        .fnum_lfo (cap_q.fnum_lfo),
        .fnum_hi  (cap_q.fnum_hi),
        .block    (cap_q.block),
        .dt       (cap_q.dt),
        .bfd      (bfd)
    );

    // mul==0 means a multiple of one half.
    always_comb begin
        prod  = {4'b0, bfd} * {{BF_W{1'b0}}, cap_q.mul};
        inc_d = (cap_q.mul == 4'd0) ? PHASE_W'(bfd >> 1) : PHASE_W'(prod);
    end

    // Stage B: increment and its phase-reset flag move on together at c2.
    always_ff @(posedge MCLK) begin
        if (IC) begin
            inc_q          <= '0;
            pg_reset_dly_q <= 1'b0;
        end else if (c2) begin
            inc_q          <= inc_d;
            pg_reset_dly_q <= cap_q.pg_reset;
        end
    end

    assign ring_head = pg_reset_dly_q ? '0 : (ring_tail + inc_q);

    // One shift register per phase bit; the tail is this slot's value from one pass ago.
    for (genvar b = 0; b < PHASE_W; b++) begin : g_plane
        ym3438_sr_bit_array #(
            .DATA_WIDTH (1),
            .LEN        (SLOTS)
        ) u_plane (
            .MCLK     (MCLK),
            .rst      (IC),
            .en       (c2),
            .data_in  (ring_head[b]),
            .data_out (ring_tail[b])
        );
    end

    always_ff @(posedge MCLK) begin
        if (IC) begin
            phase_q <= '0;
        end else if (c2) begin
            phase_q <= ring_head[PHASE_W-1 -: 10];
        end
    end

    assign phase_out = phase_q;

`ifdef PG_DBG_EN
    logic [4:0] slot_q;

    always_ff @(posedge MCLK) begin
        if (IC) begin
            slot_q <= '0;
        end else if (c2) begin
            slot_q <= (slot_q == 5'(SLOTS - 1)) ? 5'd0 : (slot_q + 5'd1);
        end
    end

    assign pg_inc_dbg  = 20'(inc_q);
    assign pg_slot_dbg = slot_q;
`endif

endmodule

// File: tb/tb_ym3438_phase_gen.sv
// Randomised bench for ym3438_phase_gen against a per-slot arithmetic phase model.
// Detune is recomputed from the OPN2 exponent/mantissa formula rather than a table.
module tb_ym3438_phase_gen;

    logic        MCLK = 1'b0;
    logic        IC;
    logic        c1;
    logic        c2;
    logic [11:0] fnum_lfo;
    logic [2:0]  fnum_hi;
    logic [2:0]  block;
    logic [2:0]  dt;
    logic [3:0]  mul;
    logic        pg_reset;
    logic [9:0]  phase_out;
`ifdef PG_DBG_EN
    logic [19:0] pg_inc_dbg;
    logic [4:0]  pg_slot_dbg;
`endif

    always #5 MCLK = ~MCLK;

    ym3438_phase_gen dut (
        .MCLK      (MCLK),
        .IC        (IC),
        .c1        (c1),
        .c2        (c2),
        .fnum_lfo  (fnum_lfo),
        .fnum_hi   (fnum_hi),
        .block     (block),
        .dt        (dt),
        .mul       (mul),
        .pg_reset  (pg_reset),
        .phase_out (phase_out)
`ifdef PG_DBG_EN
        ,
        .pg_inc_dbg  (pg_inc_dbg),
        .pg_slot_dbg (pg_slot_dbg)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    int unsigned pg_det [8] = '{16, 17, 19, 20, 22, 24, 27, 29};
    int unsigned phase_m [24];
    int unsigned slot_idx;
    int unsigned prev_phase;
    bit          have_prev;
    int unsigned last_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (slot_idx %0d)", tag, got, exp, slot_idx);
        end
    endtask

    function automatic int unsigned ref_detune(input int unsigned kc, input int unsigned dtl);
        int unsigned k, blk, note, sum;
        if (dtl == 0) return 0;
        k    = (kc > 28) ? 28 : kc;
        blk  = k / 4;
        note = k % 4;
        sum  = blk + 9 + (((dtl == 3) ? 1 : 0) | (dtl & 2));
        return pg_det[(sum % 2) * 4 + note] >> (9 - sum / 2);
    endfunction

    function automatic int unsigned ref_inc(input int unsigned f, input int unsigned fh,
                                            input int unsigned bl, input int unsigned d,
                                            input int unsigned m);
        int unsigned bf, f10, f9, f8, f7, n4, kc, dv, bfd;
        bf  = ((f * (1 << bl)) / 4) % (1 << 17);
        f10 = (fh >> 2) & 1;
        f9  = (fh >> 1) & 1;
        f8  = fh & 1;
        f7  = (f >> 8) & 1;
        n4  = (f10 == 1) ? ((f9 | f8 | f7) != 0 ? 1 : 0) : ((f9 & f8 & f7) != 0 ? 1 : 0);
        kc  = bl * 4 + f10 * 2 + n4;
        dv  = ref_detune(kc, d % 4);
        bfd = (d >= 4) ? ((bf + (1 << 17) - dv) % (1 << 17)) : ((bf + dv) % (1 << 17));
        if (m == 0) return bfd / 2;
        return (bfd * m) % (1 << 20);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 24; i++) phase_m[i] = 0;
        slot_idx   = 0;
        have_prev  = 1'b0;
        prev_phase = 0;
        last_out   = 0;
    endtask

    task automatic scramble_inputs();
        fnum_lfo = 12'($urandom);
        fnum_hi  = 3'($urandom);
        block    = 3'($urandom);
        dt       = 3'($urandom);
        mul      = 4'($urandom);
        pg_reset = 1'($urandom);
    endtask

    task automatic do_slot(input logic [11:0] f, input logic [2:0] fh, input logic [2:0] bl,
                           input logic [2:0] d, input logic [3:0] m, input logic pr);
        int unsigned s, inc, nxt, exp_out;
        s   = slot_idx % 24;
        inc = ref_inc(f, fh, bl, d, m);
        nxt = pr ? 0 : ((phase_m[s] + inc) % (1 << 20));
        fnum_lfo = f;
        fnum_hi  = fh;
        block    = bl;
        dt       = d;
        mul      = m;
        pg_reset = pr;
        c1       = 1'b1;
        @(posedge MCLK);
        #1;
        c1 = 1'b0;
        scramble_inputs();
        repeat ($urandom_range(0, 2)) @(posedge MCLK);
        #1;
        check("hold_phase_out", phase_out, last_out);
        c2 = 1'b1;
        @(posedge MCLK);
        #1;
        c2 = 1'b0;
        exp_out = have_prev ? (prev_phase >> 10) : 0;
        check("phase_out", phase_out, exp_out);
`ifdef PG_DBG_EN
        check("pg_inc_dbg", pg_inc_dbg, inc);
        check("pg_slot_dbg", pg_slot_dbg, (slot_idx + 1) % 24);
`endif
        phase_m[s] = nxt;
        prev_phase = nxt;
        have_prev  = 1'b1;
        last_out   = exp_out;
        slot_idx++;
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, phase_out, 0);
`ifdef PG_DBG_EN
        check("rst_slot_dbg", pg_slot_dbg, 0);
        check("rst_inc_dbg", pg_inc_dbg, 0);
`endif
    endtask

    task automatic do_reset();
        c1 = 1'b0;
        c2 = 1'b0;
        IC = 1'b1;
        repeat (2) @(posedge MCLK);
        #1;
        IC = 1'b0;
        check_reset_state("rst_phase_out");
        model_clear();
    endtask

    // Reset lands between c1 and c2; the interrupted slot's c2 never happens.
    task automatic do_reset_mid();
        scramble_inputs();
        c1 = 1'b1;
        @(posedge MCLK);
        #1;
        c1 = 1'b0;
        IC = 1'b1;
        @(posedge MCLK);
        #1;
        IC = 1'b0;
        check_reset_state("midrst_phase_out");
        model_clear();
    endtask

    // mode: 0 random, 1 mul1, 2 mul0, 3 mul3, 4 wrap, 5 detune underflow, 6 pg_reset slot 5
    task automatic run_passes(input int mode, input int passes);
        logic [11:0] f;
        logic [2:0]  bl, d;
        logic [3:0]  m;
        logic        pr;
        for (int k = 0; k < passes * 24; k++) begin
            f  = 12'h4D2;
            bl = 3'd4;
            d  = 3'd0;
            m  = 4'd1;
            pr = 1'b0;
            case (mode)
                0: begin
                    f  = 12'($urandom);
                    bl = 3'($urandom);
                    d  = 3'($urandom);
                    m  = 4'($urandom);
                    pr = ($urandom_range(0, 15) == 0);
                end
                2: m = 4'd0;
                3: m = 4'd3;
                4: begin
                    f  = 12'hFFF;
                    bl = 3'd7;
                    m  = 4'd15;
                end
                5: begin
                    f  = 12'h000;
                    bl = 3'd0;
                    d  = 3'd7;
                end
                6: pr = ((slot_idx % 24) == 5);
                default: ;
            endcase
            if (mode == 0) do_slot(f, 3'($urandom), bl, d, m, pr);
            else           do_slot(f, f[11:9], bl, d, m, pr);
        end
    endtask

    initial begin
        IC = 1'b1;
        c1 = 1'b0;
        c2 = 1'b0;
        scramble_inputs();
        model_clear();
        repeat (3) @(posedge MCLK);
        #1;
        IC = 1'b0;
        check_reset_state("init_phase_out");

        run_passes(1, 3);
        do_reset_mid();
        run_passes(2, 2);
        do_reset();
        run_passes(3, 2);
        do_reset();
        run_passes(4, 3);
        do_reset();
        run_passes(5, 2);
        do_reset();
        run_passes(1, 10);
        run_passes(6, 1);
        run_passes(1, 2);
        run_passes(0, 30);
        do_reset_mid();
        run_passes(0, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
